// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional statistics counters are built when BTB_STATS_EN is defined.
module branch_target_buffer #(
    parameter int addrWidth = 15,
    parameter int ENTRIES   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Hcf,
    input  logic                 flush,
    input  logic [addrWidth-1:0] IF_pc,
    output logic                 predict_hit,
    output logic                 predict_taken,
    output logic [addrWidth-1:0] Predict_Target_pc,
    input  logic                 EXE_valid,
    input  logic [addrWidth-1:0] EXE_pc,
    input  logic                 EXE_taken,
    input  logic [addrWidth-1:0] EXE_Target_pc,
    input  logic                 EXE_pred_taken,
    output logic                 mispredict
`ifdef BTB_STATS_EN
    ,
    output logic [15:0]          stat_lookups,
    output logic [15:0]          stat_hits,
    output logic [15:0]          stat_mispredicts
`endif
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = addrWidth - 2 - IDXW;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        sat_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        sat_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [TAGW-1:0]      tag_q    [ENTRIES];
    logic [TAGW-1:0]      tag_d    [ENTRIES];
    logic [addrWidth-1:0] target_q [ENTRIES];
    logic [addrWidth-1:0] target_d [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];
    logic [1:0]           ctr_d    [ENTRIES];

    logic [IDXW-1:0] if_idx_s, exe_idx_s;
    logic [TAGW-1:0] if_tag_s, exe_tag_s;
    logic            if_hit_s, exe_hit_s;
    logic            unused_pc_bits_s;

    assign if_idx_s  = IF_pc[IDXW+1:2];
    assign if_tag_s  = IF_pc[addrWidth-1:IDXW+2];
    assign exe_idx_s = EXE_pc[IDXW+1:2];
    assign exe_tag_s = EXE_pc[addrWidth-1:IDXW+2];
    assign unused_pc_bits_s = ^{IF_pc[1:0], EXE_pc[1:0]};

    // Zero-latency lookup: reads the pre-update table, no bypass from EXE.
    always_comb begin
        if_hit_s          = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
        predict_hit       = if_hit_s;
        predict_taken     = if_hit_s & ctr_q[if_idx_s][1];
        Predict_Target_pc = if_hit_s ? target_q[if_idx_s] : {addrWidth{1'b0}};
        mispredict        = EXE_valid & (EXE_pred_taken != EXE_taken);
    end

    // Next-state table: flush beats training; Hcf freezes everything.
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        exe_hit_s = valid_q[exe_idx_s] && (tag_q[exe_idx_s] == exe_tag_s);
        if (Hcf) begin
            valid_d = valid_q;
        end else if (flush) begin
            valid_d = {ENTRIES{1'b0}};
        end else if (EXE_valid) begin
            if (exe_hit_s) begin
                if (EXE_taken) begin
                    ctr_d[exe_idx_s]    = sat_inc(ctr_q[exe_idx_s]);
                    target_d[exe_idx_s] = EXE_Target_pc;
                end else begin
                    ctr_d[exe_idx_s]    = sat_dec(ctr_q[exe_idx_s]);
                end
            end else if (EXE_taken) begin
                // Allocation silently replaces any aliasing entry.
                valid_d[exe_idx_s]  = 1'b1;
                tag_d[exe_idx_s]    = exe_tag_s;
                target_d[exe_idx_s] = EXE_Target_pc;
                ctr_d[exe_idx_s]    = 2'b10;
            end else begin
                valid_d = valid_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Table storage with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= {TAGW{1'b0}};
                target_q[i] <= {addrWidth{1'b0}};
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [15:0] stat_lookups_q, stat_lookups_d;
    logic [15:0] stat_hits_q, stat_hits_d;
    logic [15:0] stat_mispredicts_q, stat_mispredicts_d;

    // Event counters, wrapping modulo 2^16 and paused while halted.
    always_comb begin
        stat_lookups_d     = stat_lookups_q;
        stat_hits_d        = stat_hits_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (!Hcf) begin
            stat_lookups_d     = stat_lookups_q + 16'd1;
            stat_hits_d        = stat_hits_q + {15'd0, if_hit_s};
            stat_mispredicts_d = stat_mispredicts_q + {15'd0, mispredict};
        end else begin
            stat_lookups_d     = stat_lookups_q;
        end
    end

    // Counter storage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_lookups_q     <= 16'd0;
            stat_hits_q        <= 16'd0;
            stat_mispredicts_q <= 16'd0;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_hits_q        <= stat_hits_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups     = stat_lookups_q;
    assign stat_hits        = stat_hits_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed cases then random traffic
// against a behavioural table model.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst, Hcf, flush;
    logic [14:0] IF_pc;
    logic        predict_hit, predict_taken;
    logic [14:0] Predict_Target_pc;
    logic        EXE_valid, EXE_taken, EXE_pred_taken;
    logic [14:0] EXE_pc, EXE_Target_pc;
    logic        mispredict;
`ifdef BTB_STATS_EN
    logic [15:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

    branch_target_buffer #(.addrWidth(15), .ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .Hcf(Hcf), .flush(flush), .IF_pc(IF_pc),
        .predict_hit(predict_hit), .predict_taken(predict_taken),
        .Predict_Target_pc(Predict_Target_pc), .EXE_valid(EXE_valid),
        .EXE_pc(EXE_pc), .EXE_taken(EXE_taken), .EXE_Target_pc(EXE_Target_pc),
        .EXE_pred_taken(EXE_pred_taken), .mispredict(mispredict)
`ifdef BTB_STATS_EN
        , .stat_lookups(stat_lookups), .stat_hits(stat_hits),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [14:0] target;
        logic        misp;
        int          lookups;
        int          hits;
        int          misps;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Reference table: plain integers indexed by pc/4 mod 16, tag = pc/64.
    int m_valid[16], m_tag[16], m_target[16], m_ctr[16];
    int m_lookups = 0, m_hits = 0, m_misps = 0;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
        end
        m_lookups = 0; m_hits = 0; m_misps = 0;
    endtask

    task automatic step(input string nm, input bit r, input bit h, input bit f,
                        input int ifpc, input bit ev, input int epc, input bit et,
                        input int etgt, input bit ep);
        exp_t e;
        int   i, t, ei, etag;
        bit   ehit;
        @(posedge clk);
        #1;
        rst = r; Hcf = h; flush = f; IF_pc = 15'(ifpc);
        EXE_valid = ev; EXE_pc = 15'(epc); EXE_taken = et;
        EXE_Target_pc = 15'(etgt); EXE_pred_taken = ep;
        i = (ifpc / 4) % 16;
        t = ifpc / 64;
        e.name    = nm;
        e.hit     = (m_valid[i] == 1) && (m_tag[i] == t);
        e.taken   = e.hit && (m_ctr[i] >= 2);
        e.target  = e.hit ? 15'(m_target[i]) : 15'd0;
        e.misp    = ev && (ep != et);
        e.lookups = m_lookups; e.hits = m_hits; e.misps = m_misps;
        q.push_back(e);
        // Apply what the coming clock edge does.
        if (!r) begin
            model_reset();
        end else if (!h) begin
            m_lookups = (m_lookups + 1) % 65536;
            m_hits    = (m_hits + (e.hit ? 1 : 0)) % 65536;
            m_misps   = (m_misps + (e.misp ? 1 : 0)) % 65536;
            ei = (epc / 4) % 16;
            etag = epc / 64;
            ehit = (m_valid[ei] == 1) && (m_tag[ei] == etag);
            if (f) begin
                for (int k = 0; k < 16; k++) m_valid[k] = 0;
            end else if (ev && ehit && et) begin
                m_ctr[ei] = (m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3;
                m_target[ei] = etgt;
            end else if (ev && ehit) begin
                m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
            end else if (ev && et) begin
                m_valid[ei] = 1; m_tag[ei] = etag; m_target[ei] = etgt; m_ctr[ei] = 2;
            end
        end
    endtask

    task automatic look(input string nm, input int pc);
        step(nm, 1'b1, 1'b0, 1'b0, pc, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic train(input string nm, input int pc, input bit tk, input int tgt);
        step(nm, 1'b1, 1'b0, 1'b0, pc, 1'b1, pc, tk, tgt, tk);
    endtask

    task automatic chk(input string nm, input string fld, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: every negedge the DUT presents a prediction for the pending entry.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (!done && q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({predict_hit, predict_taken, Predict_Target_pc, mispredict} !==
                    {e.hit, e.taken, e.target, e.misp}) begin
                    errors++;
                    $display("FAIL %s: got hit=%b taken=%b tgt=%h misp=%b, expected hit=%b taken=%b tgt=%h misp=%b",
                             e.name, predict_hit, predict_taken, Predict_Target_pc, mispredict,
                             e.hit, e.taken, e.target, e.misp);
                end
`ifdef BTB_STATS_EN
                chk(e.name, "stat_lookups", int'(stat_lookups), e.lookups);
                chk(e.name, "stat_hits", int'(stat_hits), e.hits);
                chk(e.name, "stat_mispredicts", int'(stat_mispredicts), e.misps);
`endif
            end
        end
    end

    initial begin
        int pc, epc;
        rst = 1'b0; Hcf = 1'b0; flush = 1'b0; IF_pc = 15'd0;
        EXE_valid = 1'b0; EXE_pc = 15'd0; EXE_taken = 1'b0;
        EXE_Target_pc = 15'd0; EXE_pred_taken = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        look("reset_lookup", 32'h0040);
        train("alloc_0040", 32'h0040, 1'b1, 32'h0100);
        look("hit_0040", 32'h0040);
        train("nt1_0040", 32'h0040, 1'b0, 0);
        look("ctr01_0040", 32'h0040);
        train("nt2_0040", 32'h0040, 1'b0, 0);
        train("nt3_sat_0040", 32'h0040, 1'b0, 0);
        look("ctr00_0040", 32'h0040);
        train("t_from00", 32'h0040, 1'b1, 32'h0200);
        look("ctr01_tgt0200", 32'h0040);
        repeat (3) train("inc_sat", 32'h0040, 1'b1, 32'h0300);
        look("ctr11_0040", 32'h0040);
        train("alias_0080", 32'h0080, 1'b1, 32'h0444);
        look("alias_miss_0040", 32'h0040);
        look("alias_hit_0080", 32'h0080);
        train("nt_miss_noalloc", 32'h0044, 1'b0, 32'h0555);
        look("noalloc_0044", 32'h0044);
        train("alloc_0048", 32'h0048, 1'b1, 32'h0048);
        step("same_cycle_nobypass", 1'b1, 1'b0, 1'b0, 32'h004C, 1'b1, 32'h004C, 1'b1, 32'h0777, 1'b0);
        look("after_bypass_0048", 32'h0048);
        look("after_bypass_004C", 32'h004C);
        step("flush_with_update", 1'b1, 1'b0, 1'b1, 32'h0080, 1'b1, 32'h0050, 1'b1, 32'h0123, 1'b1);
        look("post_flush_0080", 32'h0080);
        look("post_flush_0050", 32'h0050);
        step("hcf_update", 1'b1, 1'b1, 1'b0, 32'h0050, 1'b1, 32'h0050, 1'b1, 32'h0123, 1'b0);
        step("hcf_flush", 1'b1, 1'b1, 1'b1, 32'h0050, 1'b0, 0, 1'b0, 0, 1'b0);
        look("post_hcf_0050", 32'h0050);
        train("realloc_after_flush", 32'h0080, 1'b1, 32'h0999);
        step("mispredict", 1'b1, 1'b0, 1'b0, 32'h0080, 1'b1, 32'h0080, 1'b0, 0, 1'b1);
        look("post_misp_0080", 32'h0080);
        step("reset_mid", 1'b0, 1'b1, 1'b1, 32'h0080, 1'b1, 32'h0080, 1'b1, 32'h0111, 1'b1);
        look("after_reset_0080", 32'h0080);

        for (int n = 0; n < 600; n++) begin
            pc  = int'($urandom_range(0, 3)) * 64 + int'($urandom_range(0, 15)) * 4
                  + int'($urandom_range(0, 3));
            epc = ($urandom_range(0, 3) == 0) ? pc :
                  int'($urandom_range(0, 3)) * 64 + int'($urandom_range(0, 15)) * 4
                  + int'($urandom_range(0, 3));
            step("random", ($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 29) == 0), pc, ($urandom_range(0, 3) != 0), epc,
                 1'($urandom), int'($urandom_range(0, 32767)), 1'($urandom));
        end

        @(negedge clk);
        #1;
        done = 1'b1;
        chk("drain", "pending", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
